// File: rtl/gold_cdma_pkg.sv
// Gold-code CDMA transceiver: shared constants and width helpers.
// Code length and counter widths are all derived from the LFSR width.
package gold_cdma_pkg;

  localparam int unsigned GC_LFSR_W = 5;
  localparam logic [GC_LFSR_W-1:0] GC_TAPS_A = 5'b00101;
  localparam logic [GC_LFSR_W-1:0] GC_TAPS_B = 5'b11101;
  localparam logic [GC_LFSR_W-1:0] GC_SEED_A = 5'b00001;

  function automatic int unsigned code_len(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned w);
    return $clog2(code_len(w) + 1);
  endfunction

  function automatic int unsigned sum_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gold_lfsr.sv
// Fibonacci LFSR with seed reload and registered state.
// A zero seed would lock the register, so it is replaced by 1.
module gold_lfsr
  import gold_cdma_pkg::*;
#(
  parameter int unsigned W = GC_LFSR_W,
  parameter logic [W-1:0] TAPS = GC_TAPS_A
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  input  logic         reload_i,
  input  logic [W-1:0] seed_i,
  output logic         msb_o
);

  logic [W-1:0] seed_nz;
  logic [W-1:0] state_d;
  logic [W-1:0] state_q;

  assign seed_nz = (seed_i == '0) ? W'(1) : seed_i;

  always_comb begin
    state_d = state_q;
    if (reload_i) begin
      state_d = seed_nz;
    end else if (adv_i) begin
      state_d = {state_q[W-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= seed_nz;
    end else begin
      state_q <= state_d;
    end
  end

  assign msb_o = state_q[W-1];

endmodule

// File: rtl/gold_cdma_transceiver.sv
// Multi-channel Gold-code spreader with a single-channel
// correlating receiver, one data bit per code period.
module gold_cdma_transceiver
  import gold_cdma_pkg::*;
#(
  parameter int unsigned LFSR_W = GC_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS_A = GC_TAPS_A,
  parameter logic [LFSR_W-1:0] TAPS_B = GC_TAPS_B,
  parameter logic [LFSR_W-1:0] SEED_A = GC_SEED_A,
  parameter int unsigned NUM_CH = 2,
  parameter logic [23:0] CHIP_DIV = 24'd10_000_000,
  parameter int unsigned LOCK_TOL = 4,
  localparam int unsigned SEL_W = sel_width(NUM_CH),
  localparam int unsigned SUM_W = sum_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] data_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              load_i,
  input  logic              rx_i,
  input  logic [SEL_W-1:0]  rx_sel_i,
  output logic [NUM_CH-1:0] chip_o,
  output logic [NUM_CH-1:0] gold_o,
  output logic [SUM_W-1:0]  sum_o,
  output logic              sym_strobe_o,
  output logic              rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_lock_o
);

  localparam int unsigned L = code_len(LFSR_W);
  localparam int unsigned ACC_W = acc_width(LFSR_W);
  localparam logic [ACC_W-1:0] HALF = ACC_W'((L - 1) / 2);
  localparam logic [ACC_W-1:0] LOCK_HI = ACC_W'(L - LOCK_TOL);
  localparam logic [ACC_W-1:0] LOCK_LO = ACC_W'(LOCK_TOL);
  localparam logic [LFSR_W-1:0] LAST = LFSR_W'(L - 1);

  logic [23:0]       div_d, div_q;
  logic [LFSR_W-1:0] chip_idx_d, chip_idx_q;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [NUM_CH-1:0] data_lat_d, data_lat_q;
  logic [SEL_W-1:0]  sel_lat_d, sel_lat_q;
  logic [LFSR_W-1:0] seed_d, seed_q;
  logic rx_data_d, rx_data_q;
  logic rx_lock_d, rx_lock_q;
  logic rx_valid_d, rx_valid_q;
  logic strobe_d, strobe_q;

  logic              tick, last, adv, reload, match;
  logic              a_msb;
  logic [NUM_CH-1:0] b_msb;
  logic [LFSR_W-1:0] seed_src;
  logic [SEL_W-1:0]  sel_in;
  logic [ACC_W-1:0]  agree;
  logic [SUM_W-1:0]  sum_c;

  assign tick   = (div_q == CHIP_DIV - 24'd1);
  assign last   = (chip_idx_q == LAST);
  assign adv    = tick & ~last & ~load_i;
  assign reload = load_i | (tick & last);
  // B seeds are captured on reset/load and reused at every symbol end
  assign seed_src = (rst_i | load_i) ? seed_i : seed_q;
  assign sel_in = (32'(rx_sel_i) < NUM_CH) ? rx_sel_i : '0;

  gold_lfsr #(.W(LFSR_W), .TAPS(TAPS_A)) u_lfsr_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (adv),
    .reload_i (reload),
    .seed_i   (SEED_A),
    .msb_o    (a_msb)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_b
    gold_lfsr #(.W(LFSR_W), .TAPS(TAPS_B)) u_lfsr_b (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .adv_i    (adv),
      .reload_i (reload),
      .seed_i   (seed_src ^ LFSR_W'(k)),
      .msb_o    (b_msb[k])
    );
  end

  assign gold_o = {NUM_CH{a_msb}} ^ b_msb;
  assign chip_o = data_lat_q ^ gold_o;
  assign match  = (rx_i == gold_o[sel_lat_q]);
  assign agree  = acc_q + ACC_W'(match);

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_c = sum_c + SUM_W'(chip_o[k]);
    end
  end
  assign sum_o = sum_c;

  always_comb begin
    div_d      = div_q + 24'd1;
    chip_idx_d = chip_idx_q;
    acc_d      = acc_q;
    data_lat_d = data_lat_q;
    sel_lat_d  = sel_lat_q;
    seed_d     = seed_q;
    rx_data_d  = rx_data_q;
    rx_lock_d  = rx_lock_q;
    rx_valid_d = 1'b0;
    strobe_d   = 1'b0;
    if (tick) begin
      div_d = '0;
      if (last) begin
        rx_data_d  = (agree <= HALF);
        rx_lock_d  = (agree >= LOCK_HI) || (agree <= LOCK_LO);
        rx_valid_d = 1'b1;
        strobe_d   = 1'b1;
        acc_d      = '0;
        chip_idx_d = '0;
        data_lat_d = data_i;
        sel_lat_d  = sel_in;
      end else begin
        acc_d      = agree;
        chip_idx_d = chip_idx_q + LFSR_W'(1);
      end
    end
    if (load_i) begin
      div_d      = '0;
      chip_idx_d = '0;
      acc_d      = '0;
      data_lat_d = data_i;
      sel_lat_d  = sel_in;
      seed_d     = seed_i;
      rx_data_d  = rx_data_q;
      rx_lock_d  = rx_lock_q;
      rx_valid_d = 1'b0;
      strobe_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q      <= '0;
      chip_idx_q <= '0;
      acc_q      <= '0;
      data_lat_q <= '0;
      sel_lat_q  <= '0;
      seed_q     <= seed_i;
      rx_data_q  <= 1'b0;
      rx_lock_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      chip_idx_q <= chip_idx_d;
      acc_q      <= acc_d;
      data_lat_q <= data_lat_d;
      sel_lat_q  <= sel_lat_d;
      seed_q     <= seed_d;
      rx_data_q  <= rx_data_d;
      rx_lock_q  <= rx_lock_d;
      rx_valid_q <= rx_valid_d;
      strobe_q   <= strobe_d;
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_lock_o    = rx_lock_q;
  assign rx_valid_o   = rx_valid_q;
  assign sym_strobe_o = strobe_q;

endmodule

// File: tb/tb_gold_cdma_transceiver.sv
// Bench for gold_cdma_transceiver: phase-based reference model
// plus directed scenarios with hand-derived expectations.
module tb_gold_cdma_transceiver;

  localparam int NCH = 2;
  localparam int L   = 31;
  localparam int SYM = 2 * L;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [1:0] data_i;
  logic [4:0] seed_i;
  logic       load_i;
  logic       rx_i = 1'b0;
  logic       rx_sel_i;
  logic [1:0] chip_o, gold_o, sum_o;
  logic       sym_strobe_o, rx_data_o, rx_valid_o, rx_lock_o;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic ga [L];
  logic gb [NCH][L];
  int   ph = 0;
  logic [1:0] m_data;
  int   m_sel, m_acc, m_agree;
  logic m_rxd, m_lock, m_valid;
  bit   model_ok = 0;

  // receive stimulus selection
  bit   rx_loop = 1;
  int   loop_ch = 0;
  logic rx_fixed = 1'b0;

  gold_cdma_transceiver #(.CHIP_DIV(24'd2)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .seed_i       (seed_i),
    .load_i       (load_i),
    .rx_i         (rx_i),
    .rx_sel_i     (rx_sel_i),
    .chip_o       (chip_o),
    .gold_o       (gold_o),
    .sum_o        (sum_o),
    .sym_strobe_o (sym_strobe_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_lock_o    (rx_lock_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // one code period of each sequence, straight from the generator rule
  task automatic fill_tables(input logic [4:0] sd);
    logic [4:0] a;
    logic [4:0] b [NCH];
    a = 5'b00001;
    for (int k = 0; k < NCH; k++) begin
      b[k] = sd ^ 5'(k);
      if (b[k] == 5'd0) b[k] = 5'd1;
    end
    for (int c = 0; c < L; c++) begin
      ga[c] = a[4];
      a = {a[3:0], ^(a & 5'b00101)};
      for (int k = 0; k < NCH; k++) begin
        gb[k][c] = b[k][4];
        b[k] = {b[k][3:0], ^(b[k] & 5'b11101)};
      end
    end
  endtask

  always @(posedge clk) begin
    int c;
    logic g;
    if (rst_i) begin
      fill_tables(seed_i);
      ph = 0; m_data = '0; m_sel = 0; m_acc = 0;
      m_rxd = 0; m_lock = 0; m_valid = 0;
      model_ok = 1;
    end else if (load_i) begin
      fill_tables(seed_i);
      ph = 0; m_data = data_i; m_acc = 0; m_valid = 0;
      m_sel = (int'(rx_sel_i) < NCH) ? int'(rx_sel_i) : 0;
    end else begin
      m_valid = 0;
      if (ph % 2 == 1) begin
        c = (ph / 2) % L;
        g = ga[c] ^ gb[m_sel][c];
        if (c == L - 1) begin
          m_agree = m_acc + ((rx_i == g) ? 1 : 0);
          m_rxd   = (m_agree <= (L - 1) / 2);
          m_lock  = (m_agree >= L - 4) || (m_agree <= 4);
          m_valid = 1;
          m_acc   = 0;
          m_data  = data_i;
          m_sel   = (int'(rx_sel_i) < NCH) ? int'(rx_sel_i) : 0;
        end else begin
          m_acc += (rx_i == g) ? 1 : 0;
        end
      end
      ph++;
    end
  end

  always @(negedge clk) begin
    int c;
    logic [1:0] eg, ec;
    if (model_ok) begin
      c = (ph / 2) % L;
      for (int k = 0; k < NCH; k++) eg[k] = ga[c] ^ gb[k][c];
      ec = eg ^ m_data;
      chk("gold_o", gold_o, eg);
      chk("chip_o", chip_o, ec);
      chk("sum_o", sum_o, $countones(ec));
      chk("sym_strobe_o", sym_strobe_o, m_valid);
      chk("rx_valid_o", rx_valid_o, m_valid);
      chk("rx_data_o", rx_data_o, m_rxd);
      chk("rx_lock_o", rx_lock_o, m_lock);
      rx_i = rx_loop ? ec[loop_ch] : rx_fixed;
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid_o && n < 300);
    compared++;
    if (!rx_valid_o) begin
      mismatched++;
      $display("FAIL wait_valid: no pulse within %0d cycles", n);
    end
  endtask

  task automatic wait_phase(input int p);
    int i;
    i = 0;
    while ((ph % SYM) != p && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("reach_phase", ph % SYM, p);
  endtask

  initial begin
    logic [6:0] lit;
    int n, vcnt, maxs;
    rst_i = 1; load_i = 0; data_i = 2'b01;
    seed_i = 5'b00011; rx_sel_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_lock", rx_lock_o, 0);
    chk("rst_gold", gold_o, 2'b00);
    chk("rst_sum", sum_o, 0);
    rst_i = 0;

    // chips 0..6 of A(00001) ^ B(00011), worked out by hand
    lit = 7'b1001000;
    for (int c = 0; c < 7; c++) begin
      chk("model_gold_pin", ga[c] ^ gb[0][c], lit[c]);
      chk("dut_gold_pin", gold_o[0], lit[c]);
      repeat (2) @(negedge clk);
    end

    // loopback of channel 0 onto the receiver
    wait_valid(n);
    chk("sym1_data", rx_data_o, 0);
    chk("sym1_lock", rx_lock_o, 1);
    chk("sym1_strobe", sym_strobe_o, 1);
    chk("sym1_agree", m_agree, 31);
    wait_valid(n);
    chk("sym_interval", n, SYM);
    chk("sym2_data", rx_data_o, 1);
    chk("sym2_lock", rx_lock_o, 1);
    chk("sym2_agree", m_agree, 0);
    data_i = 2'b00;
    wait_valid(n);
    chk("sym3_data", rx_data_o, 1);
    wait_valid(n);
    chk("sym4_data", rx_data_o, 0);
    chk("sym4_lock", rx_lock_o, 1);

    // cross-correlation: channel 1 chips despread as channel 0
    load_i = 1; loop_ch = 1; rx_sel_i = 0;
    @(negedge clk);
    load_i = 0;
    chk("load_keeps_data", rx_data_o, 0);
    chk("load_keeps_lock", rx_lock_o, 1);
    wait_valid(n);
    chk("xcorr_interval", n, SYM);
    chk("xcorr_lock", rx_lock_o, m_lock);

    // both channels set, zero-seed substitution on B1
    data_i = 2'b11; seed_i = 5'b00001; loop_ch = 0;
    load_i = 1;
    @(negedge clk);
    load_i = 0;
    chk("sum_chip0", sum_o, 2);
    maxs = 0;
    for (int i = 0; i < SYM; i++) begin
      if (int'(sum_o) > maxs) maxs = int'(sum_o);
      @(negedge clk);
    end
    chk("sum_max", maxs, 2);

    // load at chip 10 restarts the symbol with no decision
    wait_phase(20);
    data_i = 2'b10;
    load_i = 1;
    @(posedge clk);
    #1 load_i = 0;
    n = 0; vcnt = 0;
    while (!sym_strobe_o && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (rx_valid_o && !sym_strobe_o) vcnt++;
    end
    chk("load_strobe_delay", n, SYM);
    chk("load_no_valid", vcnt, 0);

    // reset mid-symbol discards the partial accumulation
    wait_phase(30);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk("mid_rst_lock", rx_lock_o, 0);
    chk("mid_rst_valid", rx_valid_o, 0);
    chk("mid_rst_gold", gold_o, 2'b00);
    chk("mid_rst_chip", chip_o, 2'b00);
    wait_valid(n);
    chk("post_rst_interval", n, SYM);
    chk("post_rst_data", rx_data_o, 0);
    chk("post_rst_lock", rx_lock_o, 1);
    chk("post_rst_agree", m_agree, 31);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
